// File: rtl/spi_pkg.sv
// Shared SPI types and constants: FSM state encoding, default word width,
// clock-mode descriptor and a counter-width helper.
package spi_pkg;

    localparam int W_SPI_DATA = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_shifter_if.sv
// Word-level handshake between the CPU-side SPI register file (master)
// and the serial engine (slave).
interface spi_master_shifter_if
    import spi_pkg::*;
#(
    parameter int W_DATA = W_SPI_DATA
);

    logic [W_DATA-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [W_DATA-1:0] rx_data;
    logic              rx_valid;
    logic              busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy
    );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI engine: counts 0..CLK_DIV-1 and flags the
// last count as a tick; a clear restarts the count from zero.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int               W_CNT    = cnt_width(CLK_DIV);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(CLK_DIV - 1);

    logic [W_CNT-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W_CNT'(1);
        end
    end

endmodule

// File: rtl/spi_master_shifter.sv
// SPI mode-0 master engine: one MSB-first word per transaction, sclk derived
// from clk by CLK_DIV, received word returned with a one-cycle rx_valid.
module spi_master_shifter
    import spi_pkg::*;
#(
    parameter int W_DATA  = W_SPI_DATA,
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_shifter_if.slave if_bus,
    output logic                o_sclk,
    output logic                o_mosi,
    output logic                o_cs_n,
    input  logic                i_miso
);

    localparam int               W_BIT    = $clog2(W_DATA) + 1;
    localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(W_DATA);

    spi_state_e        r_state;
    logic [W_DATA-2:0] r_tx_sr;
    logic [W_DATA-1:0] r_rx_sr;
    logic [W_DATA-1:0] r_rx_data;
    logic [W_BIT-1:0]  r_bit_cnt;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic              r_tx_ready;
    logic              r_rx_valid;
    logic              r_busy;

    logic              w_tick;
    logic              w_accept;
    logic              w_shift_done;
    logic              w_state_exit;
    logic              w_div_clr;
    logic [W_DATA-1:0] w_rx_next;

    assign w_accept     = r_tx_ready && if_bus.tx_valid;
    assign w_shift_done = (r_state == SHIFT) && w_tick && !r_sclk && (r_bit_cnt == BIT_LAST);
    assign w_state_exit = w_accept
                       || (w_tick && ((r_state == SETUP) || (r_state == HOLD)))
                       || w_shift_done;
    // Holding the divider cleared in IDLE makes SETUP always start from zero.
    assign w_div_clr    = (r_state == IDLE) || w_state_exit;
    assign w_rx_next    = {r_rx_sr[W_DATA-2:0], i_miso};

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_div_clr),
        .o_tick (w_tick)
    );

    // NOTE: the shift registers are reset along with the control state, so an
    // aborted transaction leaves no partial word behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx_sr    <= '0;
            r_rx_sr    <= '0;
            r_rx_data  <= '0;
            r_bit_cnt  <= '0;
            r_sclk     <= SPI_MODE0.cpol;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx_sr    <= if_bus.tx_data[W_DATA-2:0];
                        r_mosi     <= if_bus.tx_data[W_DATA-1];
                        r_bit_cnt  <= '0;
                        r_cs_n     <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    // Entering SHIFT is itself the first rising sclk edge.
                    if (w_tick) begin
                        r_sclk    <= ~SPI_MODE0.cpol;
                        r_rx_sr   <= w_rx_next;
                        r_bit_cnt <= r_bit_cnt + W_BIT'(1);
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_sclk) begin
                            r_sclk <= 1'b0;
                            if (r_bit_cnt < BIT_LAST) begin
                                r_mosi  <= r_tx_sr[W_DATA-2];
                                r_tx_sr <= r_tx_sr << 1;
                            end
                        end else if (r_bit_cnt == BIT_LAST) begin
                            r_state <= HOLD;
                        end else begin
                            r_sclk    <= 1'b1;
                            r_rx_sr   <= w_rx_next;
                            r_bit_cnt <= r_bit_cnt + W_BIT'(1);
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_cs_n     <= 1'b1;
                        r_rx_data  <= r_rx_sr;
                        r_rx_valid <= 1'b1;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_mosi     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_bus.tx_ready = r_tx_ready;
    assign if_bus.rx_data  = r_rx_data;
    assign if_bus.rx_valid = r_rx_valid;
    assign if_bus.busy     = r_busy;
    assign o_sclk          = r_sclk;
    assign o_mosi          = r_mosi;
    assign o_cs_n          = r_cs_n;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: a 32-bit/div-2 instance and an
// 8-bit/div-1 instance, scoreboarded received words plus timing sequences.
module tb_spi_master_shifter;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    spi_master_shifter_if #(.W_DATA(32)) bus_a ();
    spi_master_shifter_if #(.W_DATA(8))  bus_b ();

    logic sclk_a, mosi_a, cs_n_a, miso_a, loop_a, miso_c_a;
    logic sclk_b, mosi_b, cs_n_b, miso_b;

    assign miso_a = loop_a ? mosi_a : miso_c_a;
    assign miso_b = mosi_b;

    spi_master_shifter #(.W_DATA(32), .CLK_DIV(2)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .if_bus (bus_a),
        .o_sclk (sclk_a),
        .o_mosi (mosi_a),
        .o_cs_n (cs_n_a),
        .i_miso (miso_a)
    );

    spi_master_shifter #(.W_DATA(8), .CLK_DIV(1)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .if_bus (bus_b),
        .o_sclk (sclk_b),
        .o_mosi (mosi_b),
        .o_cs_n (cs_n_b),
        .i_miso (miso_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tx;
        logic        loop;
        logic        miso_c;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] q_a[$];
    logic [7:0]  q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboards: every rx_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus_a.rx_valid) begin
            check("a_rx_valid_expected", q_a.size() != 0, 1);
            if (q_a.size() != 0) check("a_scoreboard_rx", bus_a.rx_data, q_a.pop_front());
        end
        if (!rst && bus_b.rx_valid) begin
            check("b_rx_valid_expected", q_b.size() != 0, 1);
            if (q_b.size() != 0) check("b_scoreboard_rx", {24'h0, bus_b.rx_data}, {24'h0, q_b.pop_front()});
        end
    end

    task automatic accept_a(input logic [31:0] word, input logic [31:0] exp_rx, input bit push);
        @(negedge clk);
        bus_a.tx_data  = word;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("a_accept_ready_low", bus_a.tx_ready, 0);
        check("a_accept_busy", bus_a.busy, 1);
        if (push) q_a.push_back(exp_rx);
        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = ~word;
    endtask

    // Counts clk edges until rx_valid, collecting sclk/cs_n/mosi activity.
    task automatic wait_rx_a(output int n, output int rises, output logic cs_hi, output logic mosi_hi);
        logic prev;
        bit   done;
        n       = 0;
        rises   = 0;
        cs_hi   = 1'b0;
        mosi_hi = mosi_a;
        prev    = sclk_a;
        done    = 1'b0;
        while (!done && n < 600) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_a.rx_valid) begin
                done = 1'b1;
            end else begin
                if (sclk_a && !prev) rises++;
                prev    = sclk_a;
                cs_hi   = cs_hi | cs_n_a;
                mosi_hi = mosi_hi | mosi_a;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   rises;
        int   pulses;
        logic cs_hi;
        logic mosi_hi;
        logic prev;

        vecs[0] = '{32'hA5A50F0F, 1'b1, 1'b0, 32'hA5A50F0F};
        vecs[1] = '{32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF};
        vecs[2] = '{32'h00000000, 1'b0, 1'b0, 32'h00000000};
        vecs[3] = '{32'h80000001, 1'b1, 1'b0, 32'h80000001};
        vecs[4] = '{32'hFFFF0000, 1'b0, 1'b1, 32'hFFFFFFFF};

        rst            = 1'b0;
        loop_a         = 1'b1;
        miso_c_a       = 1'b0;
        bus_a.tx_data  = '0;
        bus_a.tx_valid = 1'b0;
        bus_b.tx_data  = '0;
        bus_b.tx_valid = 1'b0;

        // Reset values
        #3 rst = 1'b1;
        #1;
        check("rst_tx_ready", bus_a.tx_ready, 1);
        check("rst_rx_valid", bus_a.rx_valid, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_cs_n", cs_n_a, 1);
        check("rst_rx_data", bus_a.rx_data, 0);
        check("rst_b_tx_ready", bus_b.tx_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 5; i++) begin
            loop_a   = vecs[i].loop;
            miso_c_a = vecs[i].miso_c;
            accept_a(vecs[i].tx, vecs[i].exp_rx, 1'b1);
            wait_rx_a(n, rises, cs_hi, mosi_hi);
            check($sformatf("v%0d_latency", i), n, 132);
            check($sformatf("v%0d_sclk_rises", i), rises, 32);
            check($sformatf("v%0d_cs_n_high_mid", i), cs_hi, 0);
            check($sformatf("v%0d_mosi_activity", i), mosi_hi, vecs[i].tx != 0);
            check($sformatf("v%0d_rx_data", i), bus_a.rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d_cs_n_on_done", i), cs_n_a, 1);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rx_valid_pulse", i), bus_a.rx_valid, 0);
            check($sformatf("v%0d_idle_ready", i), bus_a.tx_ready, 1);
            check($sformatf("v%0d_rx_data_held", i), bus_a.rx_data, vecs[i].exp_rx);
        end

        // Back-to-back with tx_valid held high
        loop_a = 1'b1;
        @(negedge clk);
        bus_a.tx_data  = 32'h12345678;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_first_accept", bus_a.tx_ready, 0);
        q_a.push_back(32'h12345678);
        bus_a.tx_data = 32'h9ABCDEF0;
        wait_rx_a(n, rises, cs_hi, mosi_hi);
        check("b2b_first_latency", n, 132);
        check("b2b_cs_high_on_rx_valid", cs_n_a, 1);
        check("b2b_ready_on_rx_valid", bus_a.tx_ready, 1);
        q_a.push_back(32'h9ABCDEF0);
        @(posedge clk);
        #1;
        bus_a.tx_valid = 1'b0;
        check("b2b_second_accepted", bus_a.tx_ready, 0);
        check("b2b_cs_low_again", cs_n_a, 0);
        wait_rx_a(n, rises, cs_hi, mosi_hi);
        check("b2b_second_latency", n, 132);
        check("b2b_second_rises", rises, 32);
        check("b2b_second_cs_low", cs_hi, 0);
        check("b2b_second_rx", bus_a.rx_data, 32'h9ABCDEF0);

        // tx_valid pulse while busy is ignored
        accept_a(32'h0F1E2D3C, 32'h0F1E2D3C, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus_a.tx_data  = 32'hDEADBEEF;
        bus_a.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("busy_pulse_ready_low", bus_a.tx_ready, 0);
        check("busy_pulse_busy", bus_a.busy, 1);
        bus_a.tx_valid = 1'b0;
        wait_rx_a(n, rises, cs_hi, mosi_hi);
        check("busy_pulse_latency", n, 111);
        repeat (5) @(posedge clk);
        #1;
        check("busy_pulse_rx_held", bus_a.rx_data, 32'h0F1E2D3C);
        check("busy_pulse_idle", bus_a.tx_ready, 1);
        check("busy_pulse_queue_empty", q_a.size(), 0);

        // Reset after 10 sclk rising edges
        accept_a(32'h5555AAAA, 32'h0, 1'b0);
        rises = 0;
        n     = 0;
        prev  = sclk_a;
        while (rises < 10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
        end
        check("abort_reached_10_rises", rises, 10);
        rst = 1'b1;
        #1;
        check("abort_cs_n", cs_n_a, 1);
        check("abort_sclk", sclk_a, 0);
        check("abort_mosi", mosi_a, 0);
        check("abort_tx_ready", bus_a.tx_ready, 1);
        check("abort_rx_data", bus_a.rx_data, 0);
        check("abort_busy", bus_a.busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (bus_a.rx_valid) pulses++;
        end
        check("abort_no_rx_valid", pulses, 0);
        accept_a(32'hC3C35AA5, 32'hC3C35AA5, 1'b1);
        wait_rx_a(n, rises, cs_hi, mosi_hi);
        check("post_abort_latency", n, 132);
        check("post_abort_rx", bus_a.rx_data, 32'hC3C35AA5);

        // CLK_DIV=1, W_DATA=8 loopback
        @(negedge clk);
        bus_b.tx_data  = 8'h3C;
        bus_b.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("div1_accept", bus_b.tx_ready, 0);
        q_b.push_back(8'h3C);
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = 8'hFF;
        n     = 0;
        rises = 0;
        prev  = sclk_b;
        while (!bus_b.rx_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (sclk_b && !prev) rises++;
            prev = sclk_b;
        end
        check("div1_latency", n, 18);
        check("div1_rises", rises, 8);
        check("div1_rx_data", {24'h0, bus_b.rx_data}, 32'h3C);

        repeat (3) @(posedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
